// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_ADC  = 4'd8;
   localparam logic [3:0] OP_SBB  = 4'd9;
   localparam logic [3:0] OP_SAR  = 4'd10;
   localparam logic [3:0] OP_ROL  = 4'd11;
   localparam logic [3:0] OP_ROR  = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;
   localparam logic [3:0] OP_RSV0 = 4'd14;
   localparam logic [3:0] OP_RSV1 = 4'd15;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ITER = ST_ITER,
      DONE = ST_DONE
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) ||
             (op == OP_ROL) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle result and flag path for the non-iterative opcodes.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cf_in,
   output logic [WIDTH-1:0] y,
   output logic             zf,
   output logic             sf,
   output logic             cf,
   output logic             of,
   output logic             err
);

   localparam int M = WIDTH - 1;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic           cin;

   // one shared adder and subtractor; carry-in only used by ADC/SBB
   always_comb begin
      cin = ((op == OP_ADC) || (op == OP_SBB)) ? cf_in : 1'b0;
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      y   = '0;
      cf  = 1'b0;
      of  = 1'b0;
      err = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            y  = sum[M:0];
            cf = sum[WIDTH];
            of = (a[M] == b[M]) && (y[M] != a[M]);
         end
         OP_SUB, OP_SBB: begin
            y  = dif[M:0];
            cf = dif[WIDTH];
            of = (a[M] != b[M]) && (y[M] != a[M]);
         end
         OP_AND:           y   = a & b;
         OP_OR:            y   = a | b;
         OP_XOR:           y   = a ^ b;
         OP_MOV:           y   = b;
         OP_RSV0, OP_RSV1: err = 1'b1;
         default: ;
      endcase
      zf = (y == '0);
      sf = y[M];
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops, bit-serial shifts/rotates, shift-and-add multiply.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operation
//   ITER  | one shift/rotate bit or one multiply step per cycle
//   DONE  | out_valid=1, result held until out_ready
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] cnt,
   input  logic             cf_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             zf,
   output logic             sf,
   output logic             cf,
   output logic             of,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t               state, state_n;
   logic [3:0]           op_r;
   logic [WIDTH-1:0]     work;
   logic [2*WIDTH-1:0]   prod;
   logic [CW-1:0]        iter_cnt;
   logic [CW-1:0]        n_clamp;
   logic                 accept;
   logic                 needs_iter;
   logic                 last_step;
   logic [WIDTH-1:0]     c_y;
   logic                 c_zf, c_sf, c_cf, c_of, c_err;
   logic [WIDTH-1:0]     sh_next;
   logic                 sh_out;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   prod_next;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op    (op),
      .a     (a),
      .b     (b),
      .cf_in (cf_in),
      .y     (c_y),
      .zf    (c_zf),
      .sf    (c_sf),
      .cf    (c_cf),
      .of    (c_of),
      .err   (c_err)
   );

   // clamp the requested count to WIDTH and decide whether the op iterates
   always_comb begin
      if (32'(cnt) > 32'(WIDTH)) n_clamp = CW'(WIDTH);
      else                       n_clamp = CW'(cnt);
      needs_iter = (op == OP_MUL) || (is_shift(op) && (n_clamp != '0));
      last_step  = (iter_cnt == CW'(1));
   end

   // one shift/rotate bit step and one multiply step on the working registers
   always_comb begin
      sh_next = work;
      sh_out  = 1'b0;
      case (op_r)
         OP_SHL: begin sh_out = work[WIDTH-1]; sh_next = {work[WIDTH-2:0], 1'b0};         end
         OP_SHR: begin sh_out = work[0];       sh_next = {1'b0, work[WIDTH-1:1]};         end
         OP_SAR: begin sh_out = work[0];       sh_next = {work[WIDTH-1], work[WIDTH-1:1]}; end
         OP_ROL: begin sh_out = work[WIDTH-1]; sh_next = {work[WIDTH-2:0], work[WIDTH-1]}; end
         OP_ROR: begin sh_out = work[0];       sh_next = {work[0], work[WIDTH-1:1]};       end
         default: ;
      endcase
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, work} : '0);
      prod_next = {mul_sum, prod[WIDTH-1:1]};
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next state and handshake outputs
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_n = needs_iter ? ITER : DONE;
         end
         ITER: if (last_step) state_n = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // operand capture, iteration datapath and result/flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= '0;
         work     <= '0;
         prod     <= '0;
         iter_cnt <= '0;
         y        <= '0;
         y_hi     <= '0;
         zf       <= 1'b1;
         sf       <= 1'b0;
         cf       <= 1'b0;
         of       <= 1'b0;
         err      <= 1'b0;
      end else if (accept) begin
         op_r <= op;
         work <= a;
         if (op == OP_MUL) begin
            prod     <= {{WIDTH{1'b0}}, b};
            iter_cnt <= CW'(WIDTH);
         end else if (is_shift(op)) begin
            iter_cnt <= n_clamp;
            if (n_clamp == '0) begin
               y    <= a;
               y_hi <= '0;
               zf   <= (a == '0);
               sf   <= a[WIDTH-1];
               cf   <= cf_in;
               of   <= 1'b0;
               err  <= 1'b0;
            end
         end else begin
            y    <= c_y;
            y_hi <= '0;
            zf   <= c_zf;
            sf   <= c_sf;
            cf   <= c_cf;
            of   <= c_of;
            err  <= c_err;
         end
      end else if (state == ITER) begin
         iter_cnt <= iter_cnt - CW'(1);
         if (op_r == OP_MUL) begin
            prod <= prod_next;
            if (last_step) begin
               y    <= prod_next[WIDTH-1:0];
               y_hi <= prod_next[2*WIDTH-1:WIDTH];
               zf   <= (prod_next[WIDTH-1:0] == '0);
               sf   <= prod_next[WIDTH-1];
               cf   <= (prod_next[2*WIDTH-1:WIDTH] != '0);
               of   <= (prod_next[2*WIDTH-1:WIDTH] != '0);
               err  <= 1'b0;
            end
         end else begin
            work <= sh_next;
            if (last_step) begin
               y    <= sh_next;
               y_hi <= '0;
               zf   <= (sh_next == '0);
               sf   <= sh_next[WIDTH-1];
               cf   <= sh_out;
               of   <= sh_next[WIDTH-1] ^ work[WIDTH-1];
               err  <= 1'b0;
            end
         end
      end
   end

endmodule
